// File: rtl/pipe_ctrl_pkg.sv
// Stage index constants and defaults shared by the RV32I pipeline control slice.
package pipe_ctrl_pkg;

    localparam int unsigned STG_ID  = 0;
    localparam int unsigned STG_EX  = 1;
    localparam int unsigned STG_MEM = 2;
    localparam int unsigned STG_WB  = 3;
    localparam int unsigned STG_RET = 4;

    localparam int unsigned NUM_STAGES_DEF = STG_RET + 1;
    localparam int unsigned ORDER_W_DEF    = 64;

endpackage

// File: rtl/pipe_ctrl_retire_counter.sv
// Retire order register: counts committed instructions, wraps at 2^ORDER_W.
module pipe_ctrl_retire_counter #(
    parameter int unsigned ORDER_W = 64
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               inc,
    output logic [ORDER_W-1:0] order
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            order <= '0;
        end else if (inc) begin
            order <= order + ORDER_W'(1);
        end
    end

endmodule

// File: rtl/pipe_ctrl.sv
// In-order pipeline control: per-stage valid bits, elastic stall/bubble
// decisions, branch-redirect flush and retire ordering.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned NUM_STAGES     = NUM_STAGES_DEF,
    parameter int unsigned REDIRECT_STAGE = STG_MEM,
    parameter int unsigned ORDER_W        = ORDER_W_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  fe_valid,
    output logic                  fe_pop,
    output logic                  flush_fe,
    input  logic [NUM_STAGES-1:0] stall_req,
    input  logic                  redirect,
    output logic [NUM_STAGES-1:0] stage_valid,
    output logic [NUM_STAGES-1:0] stage_en,
    output logic [NUM_STAGES-1:0] stage_bubble,
    output logic                  retire_valid,
    output logic [ORDER_W-1:0]    retire_order
);

    logic [NUM_STAGES-1:0] valid_q;
    logic [NUM_STAGES-1:0] valid_d;
    logic [NUM_STAGES:0]   ready;
    logic [NUM_STAGES-1:0] move;
    logic [NUM_STAGES-1:0] fill;
    logic                  fe_move;
    logic                  eff_redirect;

    // Backward ready chain: a stage accepts if empty, or if it drains this cycle.
    function automatic logic [NUM_STAGES:0] ready_chain(
        input logic [NUM_STAGES-1:0] v,
        input logic [NUM_STAGES-1:0] hold
    );
        logic [NUM_STAGES:0] r;
        r             = '0;
        r[NUM_STAGES] = 1'b1;
        for (int i = int'(NUM_STAGES) - 1; i >= 0; i--) begin
            r[i] = ~v[i] | (~hold[i] & r[i+1]);
        end
        return r;
    endfunction

    // Movement, redirect qualification and next valid state.
    always_comb begin
        ready        = ready_chain(valid_q, stall_req);
        move         = valid_q & ~stall_req & ready[NUM_STAGES:1];
        eff_redirect = redirect & move[REDIRECT_STAGE];
        fe_move      = fe_valid & ready[0] & ~eff_redirect;

        // fill[i]: a real instruction arrives at stage i this cycle
        fill = {move[NUM_STAGES-2:0], fe_move};
        if (eff_redirect) begin
            fill[REDIRECT_STAGE] = 1'b0;
        end

        valid_d = (fill & ready[NUM_STAGES-1:0]) | (valid_q & ~ready[NUM_STAGES-1:0]);
        if (eff_redirect) begin
            valid_d[REDIRECT_STAGE-1:0] = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q <= '0;
        end else begin
            valid_q <= valid_d;
        end
    end

    // Reset dominates every combinational control output.
    assign stage_valid  = valid_q;
    assign stage_en     = ready[NUM_STAGES-1:0] & {NUM_STAGES{rst}};
    assign stage_bubble = ready[NUM_STAGES-1:0] & ~fill & {NUM_STAGES{rst}};
    assign fe_pop       = fe_move & rst;
    assign flush_fe     = eff_redirect & rst;
    assign retire_valid = move[NUM_STAGES-1] & rst;

    pipe_ctrl_retire_counter #(
        .ORDER_W (ORDER_W)
    ) u_retire_counter (
        .clk   (clk),
        .rst   (rst),
        .inc   (retire_valid),
        .order (retire_order)
    );

endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: slot-level pipeline model plus retire-order scoreboard,
// run against a default instance and a 4-bit order instance on shared stimulus.
module tb_pipe_ctrl;

    localparam int unsigned N = 5;
    localparam int unsigned R = 2;

    logic         clk = 1'b0;
    logic         rst;
    logic         fe_valid;
    logic [N-1:0] stall_req;
    logic         redirect;

    logic         fe_pop, flush_fe, retire_valid;
    logic [N-1:0] stage_valid, stage_en, stage_bubble;
    logic [63:0]  retire_order;

    logic         b_fe_pop, b_flush_fe, b_retire_valid;
    logic [N-1:0] b_stage_valid, b_stage_en, b_stage_bubble;
    logic [3:0]   b_retire_order;

    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = -1;

    logic [N-1:0] mv;
    logic [N-1:0] mv_nxt;
    logic [63:0]  exp_q[$];
    logic [63:0]  nxt_ord;

    always #5 clk = ~clk;

    pipe_ctrl #(
        .NUM_STAGES     (N),
        .REDIRECT_STAGE (R),
        .ORDER_W        (64)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .fe_valid     (fe_valid),
        .fe_pop       (fe_pop),
        .flush_fe     (flush_fe),
        .stall_req    (stall_req),
        .redirect     (redirect),
        .stage_valid  (stage_valid),
        .stage_en     (stage_en),
        .stage_bubble (stage_bubble),
        .retire_valid (retire_valid),
        .retire_order (retire_order)
    );

    pipe_ctrl #(
        .NUM_STAGES     (N),
        .REDIRECT_STAGE (R),
        .ORDER_W        (4)
    ) dut_w4 (
        .clk          (clk),
        .rst          (rst),
        .fe_valid     (fe_valid),
        .fe_pop       (b_fe_pop),
        .flush_fe     (b_flush_fe),
        .stall_req    (stall_req),
        .redirect     (redirect),
        .stage_valid  (b_stage_valid),
        .stage_en     (b_stage_en),
        .stage_bubble (b_stage_bubble),
        .retire_valid (b_retire_valid),
        .retire_order (b_retire_order)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, got, exp);
    endtask

    // Slot model: walk oldest to youngest, a slot empties when its instruction leaves.
    task automatic model_cycle();
        logic [N-1:0] mov, en, bub, incoming;
        logic         free, take, fl;
        logic [63:0]  exp_ord;
        int           k;
        mov = '0; en = '0; bub = '0; incoming = '0;
        free = 1'b1; take = 1'b0; fl = 1'b0; k = 0;
        if (!rst) begin
            check("rst_valid", 64'(stage_valid), 64'(0));
            check("rst_ctrl", 64'({fe_pop, flush_fe, retire_valid, stage_en, stage_bubble}), 64'(0));
            check("rst_order", retire_order, 64'(0));
            check("rst_w4", 64'({b_fe_pop, b_retire_valid, b_stage_valid, b_stage_en, b_retire_order}), 64'(0));
            exp_q.delete();
            nxt_ord = '0;
            mv_nxt  = '0;
            return;
        end
        for (int i = N - 1; i >= 0; i--) begin
            if (mv[i] && !stall_req[i] && free) mov[i] = 1'b1;
            free  = !mv[i] || mov[i];
            en[i] = free;
        end
        fl   = redirect && mov[R];
        take = fe_valid && en[0] && !fl;
        incoming[0] = take;
        for (int i = 1; i < N; i++) incoming[i] = mov[i-1];
        if (fl) incoming[R] = 1'b0;
        bub = en & ~incoming;
        mv_nxt = mv;
        for (int i = 0; i < N; i++) if (en[i]) mv_nxt[i] = incoming[i];
        if (fl) begin
            for (int i = 0; i < R; i++) begin
                if (mv[i]) k++;
                mv_nxt[i] = 1'b0;
            end
        end

        check("valid", 64'(stage_valid), 64'(mv));
        check("fe_pop", 64'(fe_pop), 64'(take));
        check("flush_fe", 64'(flush_fe), 64'(fl));
        check("stage_en", 64'(stage_en), 64'(en));
        check("bubble", 64'(stage_bubble), 64'(bub));
        check("retire_valid", 64'(retire_valid), 64'(mov[N-1]));
        check("w4_ctrl", 64'({b_fe_pop, b_flush_fe, b_retire_valid, b_stage_valid, b_stage_en, b_stage_bubble}),
              64'({take, fl, mov[N-1], mv, en, bub}));

        if (retire_valid) begin
            if (exp_q.size() == 0) begin
                check("sb_empty", 64'(1), 64'(0));
            end else begin
                exp_ord = exp_q.pop_front();
                check("retire_order", retire_order, exp_ord);
                check("w4_order", 64'(b_retire_order), 64'(exp_ord[3:0]));
            end
        end
        if (fl) begin
            for (int j = 0; j < k; j++) void'(exp_q.pop_back());
            nxt_ord = nxt_ord - 64'(k);
        end
        if (take) begin
            exp_q.push_back(nxt_ord);
            nxt_ord = nxt_ord + 64'(1);
        end
    endtask

    task automatic drive(input int c);
        rst       = 1'b1;
        fe_valid  = !((c >= 30 && c <= 36) || c == 38 || (c >= 40 && c <= 43) || c >= 76);
        stall_req = '0;
        if ((c >= 10 && c <= 12) || c == 25 || c == 26) stall_req = 5'b01000;
        if (c == 42 || c == 43) stall_req = 5'b10000;
        redirect  = (c == 20) || (c >= 25 && c <= 27);
    endtask

    initial begin
        rst = 1'b0; fe_valid = 1'b0; stall_req = '0; redirect = 1'b0;
        mv = '0; mv_nxt = '0; nxt_ord = '0;
        repeat (2) @(posedge clk);
        #1 fe_valid = 1'b1;
        @(negedge clk);
        model_cycle();
        check("rst_fe_pop_forced", 64'(fe_pop), 64'(0));
        @(posedge clk);
        mv = mv_nxt;

        for (int c = 0; c < 90; c++) begin
            #1;
            cyc = c;
            drive(c);
            if (c == 55) begin
                #2 rst = 1'b0;
                #1;
                check("async_rst_valid", 64'(stage_valid), 64'(0));
                check("async_rst_order", retire_order, 64'(0));
                check("async_rst_en", 64'({stage_en, retire_valid}), 64'(0));
            end
            @(negedge clk);
            model_cycle();
            case (c)
                4:  check("no_early_retire", 64'(retire_valid), 64'(0));
                5:  check("first_retire", 64'(retire_valid), 64'(1));
                10: begin
                    check("stall_en_low", 64'(stage_en[3:0]), 64'(0));
                    check("stall_retire_once", 64'(retire_valid), 64'(1));
                end
                11, 12: check("stall_bubble4", 64'(stage_bubble[4]), 64'(1));
                20: begin
                    check("redirect_flush", 64'(flush_fe), 64'(1));
                    check("redirect_no_pop", 64'(fe_pop), 64'(0));
                end
                21: begin
                    check("flushed_young", 64'(stage_valid[2:0]), 64'(0));
                    check("branch_kept", 64'(stage_valid[3]), 64'(1));
                end
                25, 26: check("blocked_redirect", 64'(flush_fe), 64'(0));
                27: check("released_redirect", 64'(flush_fe), 64'(1));
                28: check("single_flush", 64'(flush_fe), 64'(0));
                42: begin
                    check("squeeze_v", 64'(stage_valid), 64'(5'b10100));
                    check("squeeze_bub2", 64'(stage_bubble[2]), 64'(1));
                    check("squeeze_en4", 64'(stage_en[4]), 64'(0));
                end
                43: check("squeeze_v_next", 64'(stage_valid), 64'(5'b11000));
                61: begin
                    check("post_rst_retire", 64'(retire_valid), 64'(1));
                    check("post_rst_order", retire_order, 64'(0));
                end
                default: ;
            endcase
            @(posedge clk);
            mv = mv_nxt;
        end

        check("sb_drained", 64'(exp_q.size()), 64'(0));
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
